// File: rtl/lc3b_types.sv
// Shared lc3b pipeline types: writeback packet kinds, commit-stage states
// and the condition-code value held after reset.
package lc3b_types;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      BR   = 2'd1,
      JMP  = 2'd2,
      TRAP = 2'd3
   } wb_kind_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SQUASH = 1'b1
   } wb_state_t;

   localparam logic [2:0] CC_RESET = 3'b010;

endpackage

// File: rtl/gencc_p.sv
// Condition-code generator: one-hot {n,z,p} from a two's-complement value.
module gencc_p #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] data_i,
   output logic [2:0]       cc_o
);

   always_comb begin
      if (data_i[WIDTH-1])
         cc_o = 3'b100;
      else if (data_i == '0)
         cc_o = 3'b010;
      else
         cc_o = 3'b001;
   end

endmodule

// File: rtl/wb_commit.sv
// lc3b writeback/commit stage: registered writeback with valid/ready drain,
// CC update, branch/JMP/TRAP redirect, younger-packet squash and retire count.
module wb_commit
   import lc3b_types::*;
#(
   parameter int WIDTH   = 16,
   parameter int RADDR_W = 3,
   parameter int SHADOW  = 3,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   alu_in,
   input  logic [WIDTH-1:0]   mem_in,
   input  logic [WIDTH-1:0]   br_addr,
   input  logic [WIDTH-1:0]   pc,
   input  logic [RADDR_W-1:0] dr,
   input  logic               load_regfile,
   input  logic               load_cc,
   input  logic [1:0]         cc_mux_sel,
   input  logic [2:0]         nzp,
   input  wb_kind_t           kind,
   output logic               out_valid,
   input  logic               rf_ready,
   output logic               out_we,
   output logic [RADDR_W-1:0] out_dr,
   output logic [WIDTH-1:0]   out_data,
   output logic [WIDTH-1:0]   wb_pc,
   output logic               redirect,
   output logic [WIDTH-1:0]   redirect_pc,
   output logic               pip_flush,
   output logic [2:0]         cc_out,
   output logic [CNT_W-1:0]   retired
);

   // Counter is sized so SHADOW=0 still yields a legal one-bit register.
   localparam int SQ_W = (SHADOW < 1) ? 1 : $clog2(SHADOW + 1);

   wb_state_t          state_q, state_d;
   logic [SQ_W-1:0]    sq_cnt_q, sq_cnt_d;
   logic               out_valid_q, out_valid_d;
   logic               out_we_q, out_we_d;
   logic [RADDR_W-1:0] out_dr_q, out_dr_d;
   logic [WIDTH-1:0]   out_data_q, out_data_d;
   logic [WIDTH-1:0]   wb_pc_q, wb_pc_d;
   logic               redirect_q, redirect_d;
   logic [WIDTH-1:0]   redirect_pc_q, redirect_pc_d;
   logic [2:0]         cc_q, cc_d;
   logic [CNT_W-1:0]   retired_q, retired_d;

   logic             accept;
   logic             commit;
   logic             taken;
   logic [WIDTH-1:0] wbData;
   logic [2:0]       ccGen;

   assign in_ready = !out_valid_q || rf_ready;
   assign accept   = in_valid && in_ready;
   assign commit   = accept && (state_q == ST_IDLE);

   always_comb begin
      wbData = '0;
      case (cc_mux_sel)
         2'd0:    wbData = alu_in;
         2'd1:    wbData = mem_in;
         2'd2:    wbData = br_addr;
         default: wbData = '0;
      endcase
   end

   gencc_p #(.WIDTH(WIDTH)) u_gencc (
      .data_i (wbData),
      .cc_o   (ccGen)
   );

   // Branch tests the CC held before this packet's own update.
   always_comb begin
      taken = 1'b0;
      case (kind)
         BR:      taken = |(nzp & cc_q);
         JMP:     taken = 1'b1;
         TRAP:    taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      sq_cnt_d = sq_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (commit && taken && (SHADOW > 0)) begin
               state_d  = ST_SQUASH;
               sq_cnt_d = SQ_W'(SHADOW);
            end
         end
         ST_SQUASH: begin
            if (accept) begin
               sq_cnt_d = sq_cnt_q - 1'b1;
               if (sq_cnt_q == SQ_W'(1))
                  state_d = ST_IDLE;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            sq_cnt_d = '0;
         end
      endcase
   end

   // A fresh commit reloads the output register even while it drains.
   always_comb begin
      out_valid_d   = out_valid_q;
      out_we_d      = out_we_q;
      out_dr_d      = out_dr_q;
      out_data_d    = out_data_q;
      wb_pc_d       = wb_pc_q;
      redirect_d    = commit && taken;
      redirect_pc_d = redirect_pc_q;
      cc_d          = cc_q;
      retired_d     = retired_q;
      if (commit) begin
         out_valid_d = 1'b1;
         out_we_d    = load_regfile;
         out_dr_d    = dr;
         out_data_d  = wbData;
         wb_pc_d     = pc;
         retired_d   = retired_q + CNT_W'(1);
         if (load_cc)
            cc_d = ccGen;
         if (taken)
            redirect_pc_d = (kind == TRAP) ? mem_in : br_addr;
      end else if (rf_ready) begin
         out_valid_d = 1'b0;
         out_we_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         sq_cnt_q      <= '0;
         out_valid_q   <= 1'b0;
         out_we_q      <= 1'b0;
         out_dr_q      <= '0;
         out_data_q    <= '0;
         wb_pc_q       <= '0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         cc_q          <= CC_RESET;
         retired_q     <= '0;
      end else begin
         state_q       <= state_d;
         sq_cnt_q      <= sq_cnt_d;
         out_valid_q   <= out_valid_d;
         out_we_q      <= out_we_d;
         out_dr_q      <= out_dr_d;
         out_data_q    <= out_data_d;
         wb_pc_q       <= wb_pc_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         cc_q          <= cc_d;
         retired_q     <= retired_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_we      = out_we_q;
   assign out_dr      = out_dr_q;
   assign out_data    = out_data_q;
   assign wb_pc       = wb_pc_q;
   assign redirect    = redirect_q;
   assign pip_flush   = redirect_q;
   assign redirect_pc = redirect_pc_q;
   assign cc_out      = cc_q;
   assign retired     = retired_q;

endmodule
